// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- 8-requester round-robin arbiter feeding a 3-to-8 decoder.
//
// grant_idx is the decoder select and grant_en is the decoder enable. The
// decoded grant vector is therefore one-hot while a grant is held, and zero
// otherwise. A grant is held until its owner pulses done or drops its request.
// After that, the highest priority moves to the index just past the last owner.
// There is always one idle cycle between two grants, so the decoded vector
// goes to zero between owners.
//
// Optional feature macro: RR_TIMEOUT_EN. When it is defined, a grant that
// lasts MAX_HOLD cycles without being released is released by force, and
// timeout pulses for one cycle afterwards.
//
// Ports:
//   clk        in   1  clock; all state changes on the rising edge
//   rst        in   1  synchronous, active-high reset
//   req        in   8  request lines; req[i] high = requester i wants the resource
//   done       in   1  release pulse from the current owner (ignored when idle)
//   grant_idx  out  3  index of the current owner (decoder select)
//   grant_en   out  1  grant valid (decoder enable)
//   busy       out  1  arbiter is holding a grant
//   timeout    out  1  one-cycle pulse after a forced release (always 0 without RR_TIMEOUT_EN)
//
// Parameters:
//   RESET_PTR  requester index that has the highest priority after reset
//   MAX_HOLD   grant length limit in cycles, legal range 2..255 (used only with RR_TIMEOUT_EN)

module rr_arbiter_8 #(
  parameter logic [2:0] RESET_PTR = 3'd0,
  parameter int         MAX_HOLD  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_en,
  output logic       busy,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] grant_idx_reg, grant_idx_next;
  logic       grant_en_reg, grant_en_next;
  logic       busy_reg, busy_next;
  logic       timeout_reg, timeout_next;

  // The request vector is rotated so that bit 0 is the line at ptr_reg.
  // A plain lowest-set-bit search over the rotated vector then gives the
  // round-robin order. The 3-bit addition wraps index 7 around to 0.
  logic [7:0] req_rot;
  logic [2:0] offset;
  logic [2:0] winner;
  logic       any_req;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr_reg + 3'(gi)];
    end
  endgenerate

  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) offset = 3'(k);
    end
  end

  assign any_req = |req;
  assign winner  = ptr_reg + offset;

  // A normal release happens when the owner pulses done or drops its own line.
  logic normal_release;
  logic force_release;
  assign normal_release = done | ~req[grant_idx_reg];

`ifdef RR_TIMEOUT_EN
  // hold_reg is 0 in every idle cycle. It therefore starts at 0 on the
  // first grant cycle and equals k-1 during the k-th grant cycle.
  logic [7:0] hold_reg;

  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE) hold_reg <= 8'd0;
    else                          hold_reg <= hold_reg + 8'd1;
  end

  assign force_release = (hold_reg == 8'(MAX_HOLD - 1));
`else
  assign force_release = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    grant_idx_next = grant_idx_reg;
    grant_en_next  = grant_en_reg;
    busy_next      = busy_reg;
    timeout_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next     = GRANT;
          grant_idx_next = winner;
          grant_en_next  = 1'b1;
          busy_next      = 1'b1;
        end
      end
      GRANT: begin
        if (normal_release || force_release) begin
          state_next    = IDLE;
          grant_en_next = 1'b0;
          busy_next     = 1'b0;
          ptr_next      = grant_idx_reg + 3'd1;
          // If a normal release happens on the same edge, it wins and no
          // timeout is reported.
          timeout_next  = force_release & ~normal_release;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= RESET_PTR;
      grant_idx_reg <= 3'd0;
      grant_en_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      grant_idx_reg <= grant_idx_next;
      grant_en_reg  <= grant_en_next;
      busy_reg      <= busy_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign grant_idx = grant_idx_reg;
  assign grant_en  = grant_en_reg;
  assign busy      = busy_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8. It first runs directed scenarios, then randomized
// traffic. A behavioural reference model works from the arbitration rules and
// is checked against the DUT outputs after every clock edge. A few literal
// expectations pin the model to known hand-computed values.

module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 16;
`ifdef RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] grant_idx;
  logic       grant_en;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  rr_arbiter_8 #(.RESET_PTR(3'd0), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_idx(grant_idx), .grant_en(grant_en), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model. m_owner is -1 when nothing is granted. m_held counts
  // how many grant cycles the current owner has already had.
  int m_owner = -1;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_to    = 0;

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      end
      if (m_owner >= 0) begin
        m_idx = m_owner;
        m_held = 1;
      end
    end else begin
      bit normal, forced;
      normal = done || !req[m_owner];
      forced = TO_EN && (m_held == MAX_HOLD);
      if (normal || forced) begin
        m_ptr = (m_owner + 1) % 8;
        m_owner = -1;
        m_to = (forced && !normal) ? 1 : 0;
      end else begin
        m_held++;
        m_to = 0;
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    cmp("grant_en", int'(grant_en), (m_owner >= 0) ? 1 : 0);
    cmp("busy",     int'(busy),     (m_owner >= 0) ? 1 : 0);
    cmp("grant_idx", int'(grant_idx), m_idx);
    cmp("timeout",  int'(timeout),  m_to);
  endtask

  // One clock: apply the inputs, let the edge happen, advance the model,
  // then compare 1 ns after the edge.
  task automatic cyc(input logic [7:0] r, input logic d, input logic rs);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    int seq_ok;
    int en_cnt;
    int to_seen;
    logic [7:0] r;
    logic d, rs;

    // Reset state.
    do_reset();
    cmp("reset_en", int'(grant_en), 0);
    cmp("reset_idx", int'(grant_idx), 0);

    // T1: a single request on line 2, then done. ptr then moves to 3.
    cyc(8'h04, 1'b0, 1'b0);
    cmp("t1_en", int'(grant_en), 1);
    cmp("t1_idx", int'(grant_idx), 2);
    cyc(8'h04, 1'b1, 1'b0);
    cmp("t1_release", int'(grant_en), 0);
    cyc(8'h0C, 1'b0, 1'b0);
    cmp("t1_ptr3", int'(grant_idx), 3);
    cyc(8'h00, 1'b0, 1'b0);

    // T2: all lines requesting. Owners go 0..7 then 0, with one idle cycle
    // between grants.
    do_reset();
    seq_ok = 1;
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 1'b0, 1'b0);
      if (!grant_en || int'(grant_idx) != (i % 8)) seq_ok = 0;
      cyc(8'hFF, 1'b1, 1'b0);
      if (grant_en) seq_ok = 0;
    end
    cmp("t2_sequence", seq_ok, 1);

    // T3: ptr=6 and req lines 6 and 0. Line 6 wins first, then the search
    // wraps to line 0.
    do_reset();
    cyc(8'h20, 1'b0, 1'b0);
    cyc(8'h20, 1'b1, 1'b0);
    cyc(8'h41, 1'b0, 1'b0);
    cmp("t3_first", int'(grant_idx), 6);
    cyc(8'h41, 1'b1, 1'b0);
    cyc(8'h41, 1'b0, 1'b0);
    cmp("t3_wrap", int'(grant_idx), 0);
    cyc(8'h00, 1'b0, 1'b0);

    // T4: owner 3 keeps its grant while another line changes. The grant is
    // released as soon as owner 3 drops its request.
    do_reset();
    cyc(8'h08, 1'b0, 1'b0);
    cyc(8'h28, 1'b0, 1'b0);
    cmp("t4_hold_idx", int'(grant_idx), 3);
    cmp("t4_hold_en", int'(grant_en), 1);
    cyc(8'h20, 1'b0, 1'b0);
    cmp("t4_drop", int'(grant_en), 0);
    cyc(8'h20, 1'b0, 1'b0);
    cmp("t4_next", int'(grant_idx), 5);
    cyc(8'h00, 1'b0, 1'b0);

    // T5: reset while line 4 holds the grant.
    do_reset();
    cyc(8'h10, 1'b0, 1'b0);
    cyc(8'h10, 1'b0, 1'b1);
    cmp("t5_rst_en", int'(grant_en), 0);
    cmp("t5_rst_idx", int'(grant_idx), 0);
    cyc(8'h10, 1'b0, 1'b0);
    cmp("t5_regrant", int'(grant_idx), 4);
    cyc(8'h00, 1'b0, 1'b0);

`ifdef RR_TIMEOUT_EN
    // T6: a grant with no release is held for exactly MAX_HOLD cycles,
    // followed by a one-cycle timeout pulse.
    do_reset();
    en_cnt = 0;
    to_seen = 0;
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      cyc(8'h02, 1'b0, 1'b0);
      if (grant_en && to_seen == 0) en_cnt++;
      if (timeout) to_seen++;
      if (to_seen > 0 && grant_en) i = 3 * MAX_HOLD;
    end
    cmp("t6_hold_len", en_cnt, MAX_HOLD);
    cmp("t6_to_pulses", to_seen, 1);
    // If done arrives on the final cycle, the release is normal and no
    // timeout is reported.
    do_reset();
    cyc(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) cyc(8'h02, 1'b0, 1'b0);
    cyc(8'h02, 1'b1, 1'b0);
    cmp("t6_done_en", int'(grant_en), 0);
    cmp("t6_done_to", int'(timeout), 0);
    cyc(8'h00, 1'b0, 1'b0);
`endif

    // Randomized traffic. While a grant is held, the owner's line is kept
    // high most of the time so that some grants last long.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      if (m_owner >= 0 && $urandom_range(0, 15) != 0) r[m_owner] = 1'b1;
      d  = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 299) == 0);
      cyc(r, d, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
